// File: rtl/led_output_device_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : led_output_device_pkg                                         |
// | Purpose  : Shared I/O device definitions. CTRL register bit positions    |
// |            common to the switch, key and LED devices, plus a helper that |
// |            assembles a CTRL read word from its live/stored status bits.  |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package led_output_device_pkg;

  localparam int READY_BIT   = 0;
  localparam int EMPTY_BIT   = 1;
  localparam int OVERRUN_BIT = 2;
  localparam int IE_BIT      = 8;

  typedef struct packed {
    logic ie;
    logic overrun;
    logic empty;
    logic ready;
  } ctrl_status_t;

  // Builds the 32-bit CTRL read word; undefined bits read as zero.
  function automatic logic [31:0] pack_ctrl(input ctrl_status_t s);
    logic [31:0] w;
    w              = '0;
    w[READY_BIT]   = s.ready;
    w[EMPTY_BIT]   = s.empty;
    w[OVERRUN_BIT] = s.overrun;
    w[IE_BIT]      = s.ie;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_output_device_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : led_output_device_sync_fifo                                   |
// | Purpose  : Small synchronous FIFO with a combinational head. A pop takes |
// |            effect on the same edge as it is requested; a push while full |
// |            is accepted when a pop happens in the same cycle.             |
// | Ports    : clk, reset (sync, active-high), push, pop, din[WIDTH],        |
// |            head[WIDTH], full, empty                                      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module led_output_device_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  // One extra bit so that DEPTH (full) is distinct from 0 (empty).
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // When full, the slot being written is the one the simultaneous pop frees.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Storage needs no reset: entries are only visible between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_output_device.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : led_output_device                                             |
// | Purpose  : Memory-mapped LED output peripheral. Patterns written to the  |
// |            DATA address are queued and shown on ledr one per PACE_TIME   |
// |            cycles. CTRL exposes ready/empty/overrun and interrupt enable.|
// | Ports    : clk, reset (sync, active-high), we, re, memAddr[BITS],        |
// |            dataBusIn[BITS], dataBusOut[BITS] (comb), ledr[LED_WIDTH]     |
// |            (registered), intr (IE & ready)                               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module led_output_device
  import led_output_device_pkg::*;
#(
  parameter int              LED_WIDTH  = 10,
  parameter int              BITS       = 32,
  parameter logic [BITS-1:0] BASE       = 32'hF0000004,
  parameter logic [BITS-1:0] CTRL_BASE  = 32'hF0000104,
  parameter int              FIFO_DEPTH = 4,
  parameter int              PACE_TIME  = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic                 re,
  input  logic [BITS-1:0]      memAddr,
  input  logic [BITS-1:0]      dataBusIn,
  output logic [BITS-1:0]      dataBusOut,
  output logic [LED_WIDTH-1:0] ledr,
  output logic                 intr
);

  localparam int CW = $clog2(PACE_TIME);

  logic                 wr_data;
  logic                 wr_ctrl;
  logic                 rd_data;
  logic                 rd_ctrl;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic [LED_WIDTH-1:0] fifo_head;
  logic [CW-1:0]        pace_cnt;
  logic                 overrun;
  logic                 ie;
  ctrl_status_t         status;

  // Only the low LED bits and CTRL bits 2/8 of the write data are meaningful.
  logic unused_data_bits;
  assign unused_data_bits = &{1'b0, dataBusIn};

  assign wr_data = we & (memAddr == BASE);
  assign wr_ctrl = we & (memAddr == CTRL_BASE);
  assign rd_data = re & ~we & (memAddr == BASE);
  assign rd_ctrl = re & ~we & (memAddr == CTRL_BASE);

  assign fifo_pop = ~fifo_empty & (pace_cnt == '0);

  led_output_device_sync_fifo #(
    .WIDTH (LED_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_data),
    .pop   (fifo_pop),
    .din   (dataBusIn[LED_WIDTH-1:0]),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pace_cnt <= '0;
      ledr     <= '0;
    end else if (fifo_pop) begin
      ledr     <= fifo_head;
      pace_cnt <= CW'(PACE_TIME - 1);
    end else if (pace_cnt != '0) begin
      pace_cnt <= pace_cnt - CW'(1);
    end
  end

  // DATA and CTRL decode are mutually exclusive, so the two overrun updates
  // never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
      ie      <= 1'b0;
    end else begin
      if (wr_data & fifo_full & ~fifo_pop) begin
        overrun <= 1'b1;
      end else if (wr_ctrl) begin
        overrun <= overrun & dataBusIn[OVERRUN_BIT];
      end
      if (wr_ctrl) begin
        ie <= dataBusIn[IE_BIT];
      end
    end
  end

  assign status.ready   = ~fifo_full;
  assign status.empty   = fifo_empty;
  assign status.overrun = overrun;
  assign status.ie      = ie;

  assign intr = ie & ~fifo_full;

  always_comb begin
    dataBusOut = '0;
    if (rd_data) begin
      dataBusOut = BITS'(ledr);
    end else if (rd_ctrl) begin
      dataBusOut = BITS'(pack_ctrl(status));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_output_device.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_led_output_device                                          |
// | Purpose  : Self-checking bench for led_output_device (PACE_TIME=4,       |
// |            FIFO_DEPTH=4, LED_WIDTH=10). A queue-based reference model    |
// |            predicts bus reads, ledr and intr every cycle; directed       |
// |            scenarios add literal expectations, then random traffic runs. |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_led_output_device;

  localparam int          LW    = 10;
  localparam int          DEPTH = 4;
  localparam int          PACE  = 4;
  localparam logic [31:0] BASE  = 32'hF0000004;
  localparam logic [31:0] CTRL  = 32'hF0000104;

  logic          clk;
  logic          reset;
  logic          we;
  logic          re;
  logic [31:0]   memAddr;
  logic [31:0]   dataBusIn;
  logic [31:0]   dataBusOut;
  logic [LW-1:0] ledr;
  logic          intr;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  led_output_device #(
    .LED_WIDTH  (LW),
    .BITS       (32),
    .BASE       (BASE),
    .CTRL_BASE  (CTRL),
    .FIFO_DEPTH (DEPTH),
    .PACE_TIME  (PACE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .re         (re),
    .memAddr    (memAddr),
    .dataBusIn  (dataBusIn),
    .dataBusOut (dataBusOut),
    .ledr       (ledr),
    .intr       (intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending patterns, shown pattern, sticky flags, and the
  // cycle number of the last time a pattern went onto the LEDs.
  int          q[$];
  int          m_ledr;
  bit          m_ie;
  bit          m_ov;
  int          cyc = 0;
  int          last_show;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_ctrl();
    logic [31:0] w;
    w    = 32'd0;
    w[0] = (q.size() < DEPTH);
    w[1] = (q.size() == 0);
    w[2] = m_ov;
    w[8] = m_ie;
    return w;
  endfunction

  always @(posedge clk) begin
    bit shows;
    if (reset) begin
      q.delete();
      m_ledr    = 0;
      m_ie      = 0;
      m_ov      = 0;
      last_show = cyc - PACE;
    end else begin
      shows = (q.size() > 0) && (cyc - last_show >= PACE);
      if (shows) begin
        m_ledr    = q.pop_front();
        last_show = cyc;
      end
      if (we && memAddr == BASE) begin
        if (q.size() < DEPTH) q.push_back(int'(dataBusIn[LW-1:0]));
        else m_ov = 1;
      end else if (we && memAddr == CTRL) begin
        m_ie = dataBusIn[8];
        m_ov = m_ov & dataBusIn[2];
      end
    end
    cyc++;
  end

  // The single per-cycle compare against the model.
  always @(negedge clk) begin
    logic [31:0] exp_bus;
    if (chk_en) begin
      exp_bus = 32'd0;
      if (re && !we && memAddr == BASE) exp_bus = 32'(m_ledr);
      else if (re && !we && memAddr == CTRL) exp_bus = m_ctrl();
      chk("dataBusOut", dataBusOut, exp_bus);
      chk("ledr", 32'(ledr), 32'(m_ledr));
      chk("intr", 32'(intr), 32'(m_ie && (q.size() < DEPTH)));
    end
  end

  // Drive inputs just after a rising edge and wait until mid-cycle, so the
  // caller can pin outputs for this cycle; adv() moves to the next cycle.
  task automatic apply(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    we        = w;
    re        = r;
    memAddr   = a;
    dataBusIn = d;
    @(negedge clk);
    #1;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      apply(1'b0, 1'b0, 32'd0, 32'd0);
      adv();
    end
  endtask

  initial begin
    int wprob;
    int sel;
    logic [31:0] a;
    reset     = 1'b1;
    we        = 1'b0;
    re        = 1'b0;
    memAddr   = 32'd0;
    dataBusIn = 32'd0;
    adv();
    chk_en = 1;
    adv();
    reset = 1'b0;

    // Reset state
    apply(1'b0, 1'b1, CTRL, 32'd0);
    chk("t1_ctrl", dataBusOut, 32'h003);
    chk("t1_ledr", 32'(ledr), 32'h0);
    chk("t1_intr", 32'(intr), 32'h0);
    adv();
    apply(1'b0, 1'b1, BASE, 32'd0);
    chk("t1_data", dataBusOut, 32'h0);
    adv();

    // Single write while idle: push edge, then pop edge
    apply(1'b1, 1'b0, BASE, 32'h155);
    chk("t2_ledr_pre", 32'(ledr), 32'h0);
    adv();
    apply(1'b0, 1'b0, 32'd0, 32'd0);
    chk("t2_ledr_edge1", 32'(ledr), 32'h0);
    adv();
    apply(1'b0, 1'b1, BASE, 32'd0);
    chk("t2_rd_data", dataBusOut, 32'h155);
    adv();
    apply(1'b0, 1'b1, CTRL, 32'd0);
    chk("t2_ctrl", dataBusOut, 32'h003);
    adv();
    idle(6);

    // Seven back-to-back writes; the seventh overflows
    for (int i = 1; i <= 7; i++) begin
      apply(1'b1, 1'b0, BASE, 32'(i));
      adv();
    end
    apply(1'b0, 1'b1, CTRL, 32'd0);
    chk("t3_ctrl_full", dataBusOut, 32'h004);
    chk("t3_ledr_mid", 32'(ledr), 32'h2);
    adv();
    idle(25);
    apply(1'b0, 1'b1, BASE, 32'd0);
    chk("t3_ledr_last", dataBusOut, 32'h6);
    adv();

    // Interrupt enable and intr tracking ready
    apply(1'b1, 1'b0, CTRL, 32'h100);
    adv();
    apply(1'b0, 1'b0, 32'd0, 32'd0);
    chk("t4_intr_on", 32'(intr), 32'h1);
    adv();
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 1'b0, BASE, 32'h10 + 32'(i));
      adv();
    end
    apply(1'b0, 1'b0, 32'd0, 32'd0);
    chk("t4_intr_full", 32'(intr), 32'h0);
    adv();
    apply(1'b0, 1'b0, 32'd0, 32'd0);
    chk("t4_intr_after_pop", 32'(intr), 32'h1);
    adv();

    // Overrun is sticky; only writing 0 to its bit clears it
    apply(1'b1, 1'b0, BASE, 32'h3A);
    adv();
    apply(1'b1, 1'b0, BASE, 32'h3B);
    adv();
    apply(1'b1, 1'b0, CTRL, 32'h104);
    adv();
    apply(1'b0, 1'b1, CTRL, 32'd0);
    chk("t5_ov_kept", dataBusOut & 32'h104, 32'h104);
    adv();
    apply(1'b1, 1'b0, CTRL, 32'h100);
    adv();
    apply(1'b0, 1'b1, CTRL, 32'd0);
    chk("t5_ov_cleared", dataBusOut & 32'h104, 32'h100);
    adv();

    // Reset while entries are still queued
    reset = 1'b1;
    apply(1'b0, 1'b0, 32'd0, 32'd0);
    adv();
    reset = 1'b0;
    apply(1'b0, 1'b1, CTRL, 32'd0);
    chk("t6_ctrl", dataBusOut, 32'h003);
    chk("t6_ledr", 32'(ledr), 32'h0);
    adv();
    idle(20);
    apply(1'b0, 1'b1, BASE, 32'd0);
    chk("t6_no_stale", dataBusOut, 32'h0);
    adv();

    // Random traffic with varying write pressure
    wprob = 30;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) wprob = $urandom_range(5, 90);
      reset = ($urandom_range(0, 299) == 0);
      sel = $urandom_range(0, 99);
      if (sel < 45) a = BASE;
      else if (sel < 80) a = CTRL;
      else a = $urandom;
      apply($urandom_range(0, 99) < wprob, $urandom_range(0, 1) == 1, a, $urandom);
      adv();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
